bme280_sequencer: RTL and testbench

BME280_SEQUENCER -- requirements
Module: bme280_sequencer

---
 rtl/bme280_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_bme280_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bme280_sequencer.sv
// BME280 access sequencer: drives an I2C wrapper through soft reset,
// measurement-control write and chip-ID check, then loops a burst read of
// pressure/temperature/humidity bytes and publishes the assembled raw values.
module bme280_sequencer #(
  parameter int          TXN_CYCLES    = 4000,
  parameter int          BOOT_CYCLES   = 200000,
  parameter int          PERIOD_CYCLES = 10000000,
  parameter logic [7:0]  CHIP_ID       = 8'h60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  data_in,
  output logic [3:0]  register_selector,
  output logic        en,
  output logic        busy,
  output logic        id_error,
  output logic        sample_valid,
  output logic [19:0] press_raw,
  output logic [19:0] temp_raw,
  output logic [15:0] hum_raw
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_CAPTURE,
    S_BOOT_WAIT,
    S_PERIOD_WAIT,
    S_ERROR
  } state_t;

  // Step indices: 0 reset write, 1 ctrl_meas write, 2 ID read, 3..10 burst
  localparam logic [3:0]  STEP_RESET = 4'd0;
  localparam logic [3:0]  STEP_ID    = 4'd2;
  localparam logic [3:0]  STEP_BURST = 4'd3;
  localparam logic [3:0]  STEP_LAST  = 4'd10;

  // Terminal counts; counters run 0..N-1
  localparam logic [31:0] TXN_LAST    = 32'(TXN_CYCLES - 1);
  localparam logic [31:0] BOOT_LAST   = 32'(BOOT_CYCLES - 1);
  localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_step;
  logic [31:0] r_cnt;
  logic [3:0]  r_sel;
  logic        r_en;
  logic        r_busy;
  logic        r_id_error;
  logic        r_sample_valid;
  logic [19:0] r_press;
  logic [19:0] r_temp;
  logic [15:0] r_hum;
  logic [7:0]  r_byte [0:7];

  logic [3:0]  w_next_step;
  logic [3:0]  w_next_code;

  // Wrapper operation code for a given step index
  function automatic logic [3:0] f_step_code(input logic [3:0] step);
    case (step)
      4'd0:    f_step_code = 4'd7;
      4'd1:    f_step_code = 4'd5;
      4'd2:    f_step_code = 4'd1;
      default: f_step_code = 4'(step + 4'd5);
    endcase
  endfunction

  // The burst wraps from the last read back to the first burst read
  assign w_next_step = (r_step == STEP_LAST) ? STEP_BURST : 4'(r_step + 4'd1);
  assign w_next_code = f_step_code(w_next_step);

  assign register_selector = r_sel;
  assign en                = r_en;
  assign busy              = r_busy;
  assign id_error          = r_id_error;
  assign sample_valid      = r_sample_valid;
  assign press_raw         = r_press;
  assign temp_raw          = r_temp;
  assign hum_raw           = r_hum;

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    r_sample_valid <= 1'b0;
    if (rst) begin
      r_state    <= S_IDLE;
      r_step     <= 4'd0;
      r_cnt      <= 32'd0;
      r_sel      <= 4'd0;
      r_en       <= 1'b0;
      r_busy     <= 1'b0;
      r_id_error <= 1'b0;
      r_press    <= 20'd0;
      r_temp     <= 20'd0;
      r_hum      <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SETUP;
            r_step  <= STEP_RESET;
            r_sel   <= f_step_code(STEP_RESET);
            r_busy  <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state <= S_XFER;
          r_en    <= 1'b1;
          r_cnt   <= 32'd0;
        end
        S_XFER: begin
          if (r_cnt == TXN_LAST) begin
            r_state <= S_CAPTURE;
            r_en    <= 1'b0;
            r_cnt   <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_CAPTURE: begin
          if (r_step == STEP_RESET) begin
            r_state <= S_BOOT_WAIT;
            r_cnt   <= 32'd0;
          end else if (r_step == STEP_ID && data_in != CHIP_ID) begin
            r_state    <= S_ERROR;
            r_id_error <= 1'b1;
            r_sel      <= 4'd0;
            r_busy     <= 1'b0;
          end else if (r_step == STEP_LAST) begin
            // Publish all three values at once; the wait counter stays
            // frozen during this pulse cycle
            r_state        <= S_PERIOD_WAIT;
            r_cnt          <= 32'd0;
            r_sample_valid <= 1'b1;
            r_press        <= {r_byte[0], r_byte[1], r_byte[2][7:4]};
            r_temp         <= {r_byte[3], r_byte[4], r_byte[5][7:4]};
            r_hum          <= {r_byte[6], data_in};
          end else begin
            r_state <= S_SETUP;
            r_step  <= w_next_step;
            r_sel   <= w_next_code;
          end
        end
        S_BOOT_WAIT: begin
          if (r_cnt == BOOT_LAST) begin
            r_state <= S_SETUP;
            r_step  <= w_next_step;
            r_sel   <= w_next_code;
            r_cnt   <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_PERIOD_WAIT: begin
          if (!r_sample_valid) begin
            if (r_cnt == PERIOD_LAST) begin
              r_state <= S_SETUP;
              r_step  <= w_next_step;
              r_sel   <= w_next_code;
              r_cnt   <= 32'd0;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
        end
        S_ERROR: begin
          r_en <= 1'b0;
        end
        default: begin
          r_state <= S_ERROR;
          r_sel   <= 4'd0;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Burst byte slots; payload storage only, so no reset
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_CAPTURE && r_step >= STEP_BURST) begin
      r_byte[3'(r_step - STEP_BURST)] <= data_in;
    end
  end

endmodule

// File: tb/tb_bme280_sequencer.sv
// Directed bench for bme280_sequencer with short wait parameters.
module tb_bme280_sequencer;

  localparam int TXN    = 4;
  localparam int BOOT   = 8;
  localparam int PERIOD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  data_in;
  logic [3:0]  register_selector;
  logic        en;
  logic        busy;
  logic        id_error;
  logic        sample_valid;
  logic [19:0] press_raw;
  logic [19:0] temp_raw;
  logic [15:0] hum_raw;

  int checks   = 0;
  int failures = 0;
  int k;

  logic [7:0] id_byte;
  logic [7:0] bb [0:7];

  logic [3:0] ref_sel [0:159];
  logic       ref_en  [0:159];
  logic       ref_sv  [0:159];

  bme280_sequencer #(
    .TXN_CYCLES   (TXN),
    .BOOT_CYCLES  (BOOT),
    .PERIOD_CYCLES(PERIOD),
    .CHIP_ID      (8'h60)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .data_in          (data_in),
    .register_selector(register_selector),
    .en               (en),
    .busy             (busy),
    .id_error         (id_error),
    .sample_valid     (sample_valid),
    .press_raw        (press_raw),
    .temp_raw         (temp_raw),
    .hum_raw          (hum_raw)
  );

  always #5 clk = ~clk;

  // Wrapper stand-in: returns the byte belonging to the selected operation
  always_comb begin
    data_in = 8'h00;
    if (register_selector == 4'd1) data_in = id_byte;
    else if (register_selector >= 4'd8) data_in = bb[register_selector[2:0]];
  end

  task automatic load_burst_a();
    bb[0] = 8'h65; bb[1] = 8'h5A; bb[2] = 8'hC0; bb[3] = 8'h7E;
    bb[4] = 8'hED; bb[5] = 8'h00; bb[6] = 8'h66; bb[7] = 8'h3B;
  endtask

  task automatic load_burst_b();
    bb[0] = 8'h12; bb[1] = 8'h34; bb[2] = 8'h56; bb[3] = 8'h78;
    bb[4] = 8'h9A; bb[5] = 8'hBC; bb[6] = 8'hDE; bb[7] = 8'hF1;
  endtask

  // Reset, then release with start high so k=0 is the first SETUP cycle
  task automatic reset_and_start();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; start = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (register_selector !== 4'd0) begin failures++; $display("FAIL reset_sel got=%0h exp=0", register_selector); end
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL reset_en got=%0b exp=0", en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (id_error !== 1'b0) begin failures++; $display("FAIL reset_id_error got=%0b exp=0", id_error); end
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_sv got=%0b exp=0", sample_valid); end
    checks++; if (press_raw !== 20'd0 || temp_raw !== 20'd0 || hum_raw !== 16'd0) begin
      failures++; $display("FAIL reset_raw got=%0h/%0h/%0h exp=0/0/0", press_raw, temp_raw, hum_raw); end
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || register_selector !== 4'd0) begin
      failures++; $display("FAIL idle_no_start busy=%0b sel=%0h exp=0/0", busy, register_selector); end
  endtask

  task automatic test_init();
    logic [3:0] tsel [0:39];
    logic       ten  [0:39];
    int rs [0:2]; int rl [0:2]; logic [3:0] rsel [0:2]; int nr;
    id_byte = 8'h60; load_burst_a();
    reset_and_start();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tsel[i] = register_selector; ten[i] = en;
      if (i == 0) begin
        checks++; if (register_selector !== 4'd7 || en !== 1'b0 || busy !== 1'b1) begin
          failures++; $display("FAIL init_setup sel=%0h en=%0b busy=%0b exp=7/0/1", register_selector, en, busy); end
      end
    end
    nr = 0;
    for (int i = 0; i < 40; i++) begin
      if (ten[i] && (i == 0 || !ten[i-1]) && nr < 3) begin
        rs[nr] = i; rsel[nr] = tsel[i]; rl[nr] = 0;
        for (int j = i; j < 40 && ten[j]; j++) begin
          rl[nr]++;
          if (tsel[j] !== tsel[i]) rl[nr] = -100;
        end
        nr++;
      end
    end
    checks++; if (nr != 3) begin failures++; $display("FAIL init_runs got=%0d exp=3", nr); end
    else begin
      checks++; if (rs[0] != 1) begin failures++; $display("FAIL init_first_en got=%0d exp=1", rs[0]); end
      checks++; if (rsel[0] !== 4'd7 || rsel[1] !== 4'd5 || rsel[2] !== 4'd1) begin
        failures++; $display("FAIL init_codes got=%0h,%0h,%0h exp=7,5,1", rsel[0], rsel[1], rsel[2]); end
      checks++; if (rl[0] != TXN || rl[1] != TXN || rl[2] != TXN) begin
        failures++; $display("FAIL init_en_len got=%0d,%0d,%0d exp=4,4,4", rl[0], rl[1], rl[2]); end
      // en-low gap after the reset write: CAPTURE + BOOT_CYCLES + SETUP
      checks++; if (rs[1] - (rs[0] + rl[0]) != BOOT + 2) begin
        failures++; $display("FAIL init_boot_gap got=%0d exp=%0d", rs[1] - (rs[0] + rl[0]), BOOT + 2); end
      // ctrl_meas to ID: CAPTURE + SETUP only
      checks++; if (rs[2] - (rs[1] + rl[1]) != 2) begin
        failures++; $display("FAIL init_txn_gap got=%0d exp=2", rs[2] - (rs[1] + rl[1])); end
    end
  endtask

  task automatic test_bad_id();
    int bad;
    id_byte = 8'h58;
    reset_and_start();
    for (int i = 0; i <= 26; i++) begin
      @(negedge clk);
      if (i == 25) begin
        checks++; if (id_error !== 1'b0 || register_selector !== 4'd1) begin
          failures++; $display("FAIL badid_pre id_error=%0b sel=%0h exp=0/1", id_error, register_selector); end
      end
    end
    checks++; if (id_error !== 1'b1 || busy !== 1'b0 || en !== 1'b0 || register_selector !== 4'd0) begin
      failures++; $display("FAIL badid_error id_error=%0b busy=%0b en=%0b sel=%0h exp=1/0/0/0", id_error, busy, en, register_selector); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      start = i[0];
      @(negedge clk);
      if (en !== 1'b0 || register_selector !== 4'd0 || busy !== 1'b0 || id_error !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL badid_hold bad_cycles=%0d exp=0", bad); end
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++; if (id_error !== 1'b0) begin failures++; $display("FAIL badid_rst_clear got=%0b exp=0", id_error); end
    rst = 1'b0;
    id_byte = 8'h60;
  endtask

  task automatic test_burst();
    int sv_cnt;
    id_byte = 8'h60; load_burst_a();
    reset_and_start();
    sv_cnt = 0;
    for (k = 0; k <= 74; k++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) sv_cnt++;
      if (k == 26) begin
        checks++; if (register_selector !== 4'd8 || en !== 1'b0) begin
          failures++; $display("FAIL burst_first_setup sel=%0h en=%0b exp=8/0", register_selector, en); end
      end
      if (k == 73) begin
        checks++; if (press_raw !== 20'd0 || hum_raw !== 16'd0 || register_selector !== 4'd15) begin
          failures++; $display("FAIL burst_mid press=%0h hum=%0h sel=%0h exp=0/0/f", press_raw, hum_raw, register_selector); end
      end
    end
    checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL burst_sv_time got=%0b exp=1", sample_valid); end
    checks++; if (press_raw !== 20'h655AC) begin failures++; $display("FAIL burst_press got=%0h exp=655ac", press_raw); end
    checks++; if (temp_raw !== 20'h7EED0) begin failures++; $display("FAIL burst_temp got=%0h exp=7eed0", temp_raw); end
    checks++; if (hum_raw !== 16'h663B) begin failures++; $display("FAIL burst_hum got=%0h exp=663b", hum_raw); end
    checks++; if (sv_cnt != 1) begin failures++; $display("FAIL burst_sv_count got=%0d exp=1", sv_cnt); end
  endtask

  // Continues directly from test_burst (k=74 was the first sample_valid)
  task automatic test_periodic();
    int unstable; int extra_sv;
    unstable = 0; extra_sv = 0;
    for (k = 75; k <= 140; k++) begin
      @(negedge clk);
      if (k == 75) begin
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL period_sv_width got=%0b exp=0", sample_valid); end
      end
      if (k == 80) load_burst_b();
      if (k < 139 && (press_raw !== 20'h655AC || temp_raw !== 20'h7EED0 || hum_raw !== 16'h663B)) unstable++;
      if (sample_valid === 1'b1 && k != 139) extra_sv++;
      if (k == 90) begin
        checks++; if (register_selector !== 4'd15 || busy !== 1'b1 || en !== 1'b0) begin
          failures++; $display("FAIL period_wait sel=%0h busy=%0b en=%0b exp=f/1/0", register_selector, busy, en); end
      end
      if (k == 91) begin
        checks++; if (register_selector !== 4'd8 || en !== 1'b0) begin
          failures++; $display("FAIL period_resetup sel=%0h en=%0b exp=8/0", register_selector, en); end
      end
      if (k == 92) begin
        checks++; if (en !== 1'b1) begin failures++; $display("FAIL period_xfer en=%0b exp=1", en); end
      end
      if (k == 139) begin
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL period_sv2 got=%0b exp=1", sample_valid); end
        checks++; if (press_raw !== 20'h12345 || temp_raw !== 20'h789AB || hum_raw !== 16'hDEF1) begin
          failures++; $display("FAIL period_raw2 got=%0h/%0h/%0h exp=12345/789ab/def1", press_raw, temp_raw, hum_raw); end
      end
    end
    checks++; if (unstable != 0) begin failures++; $display("FAIL period_raw_stable changed_cycles=%0d exp=0", unstable); end
    checks++; if (extra_sv != 0) begin failures++; $display("FAIL period_extra_sv got=%0d exp=0", extra_sv); end
  endtask

  task automatic test_reset_mid();
    id_byte = 8'h60; load_burst_a();
    reset_and_start();
    for (k = 0; k <= 111; k++) begin
      @(negedge clk);
      if (k == 80) load_burst_b();
    end
    checks++; if (en !== 1'b1 || register_selector !== 4'd11 || press_raw !== 20'h655AC) begin
      failures++; $display("FAIL rstmid_pre en=%0b sel=%0h press=%0h exp=1/b/655ac", en, register_selector, press_raw); end
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++; if (en !== 1'b0 || busy !== 1'b0 || register_selector !== 4'd0 || sample_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_ctrl en=%0b busy=%0b sel=%0h sv=%0b exp=0/0/0/0", en, busy, register_selector, sample_valid); end
    checks++; if (press_raw !== 20'd0 || temp_raw !== 20'd0 || hum_raw !== 16'd0) begin
      failures++; $display("FAIL rstmid_raw got=%0h/%0h/%0h exp=0/0/0", press_raw, temp_raw, hum_raw); end
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    checks++; if (register_selector !== 4'd7 || busy !== 1'b1 || en !== 1'b0) begin
      failures++; $display("FAIL rstmid_restart sel=%0h busy=%0b en=%0b exp=7/1/0", register_selector, busy, en); end
  endtask

  task automatic test_start_ignored();
    int diff;
    id_byte = 8'h60; load_burst_a();
    reset_and_start();
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      ref_sel[i] = register_selector; ref_en[i] = en; ref_sv[i] = sample_valid;
    end
    reset_and_start();
    diff = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if ((i >= 75 && i <= 90) || (i >= 140 && i <= 155)) start = i[0];
      else start = 1'b1;
      if (register_selector !== ref_sel[i] || en !== ref_en[i] || sample_valid !== ref_sv[i]) diff++;
      if (i == 91) begin
        checks++; if (register_selector !== 4'd8) begin
          failures++; $display("FAIL startign_resetup sel=%0h exp=8", register_selector); end
      end
      if (i == 139) begin
        checks++; if (sample_valid !== 1'b1) begin
          failures++; $display("FAIL startign_sv2 got=%0b exp=1", sample_valid); end
      end
    end
    checks++; if (diff != 0) begin failures++; $display("FAIL startign_trace diff_cycles=%0d exp=0", diff); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; id_byte = 8'h60;
    load_burst_a();
    test_reset();
    test_init();
    test_bad_id();
    test_burst();
    test_periodic();
    test_reset_mid();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
